// File: rtl/parking_gate_if.sv
// Event bus between the parking gates and the occupancy counter: loop/pass sensors and counter
// feedback flow into the controller; barrier commands, car events and statistics flow out.
interface parking_gate_if #(
   parameter int CNT_W = 16
);
   logic                    entry_req;
   logic                    entry_is_uni;
   logic                    entry_pass;
   logic                    exit_req;
   logic                    exit_is_uni;
   logic                    exit_pass;
   logic                    uni_is_vacated_space;
   logic                    is_vacated_space;
   logic signed [10:0]      uni_parked_car;
   logic signed [10:0]      parked_car;
   logic                    car_entered;
   logic                    is_uni_car_entered;
   logic                    car_exited;
   logic                    is_uni_car_exited;
   logic                    entry_gate_open;
   logic                    exit_gate_open;
   logic                    entry_denied;
   logic                    exit_denied;
   logic [CNT_W-1:0]        deny_count;
   logic [CNT_W-1:0]        timeout_count;

   modport master (
      output entry_req, entry_is_uni, entry_pass, exit_req, exit_is_uni, exit_pass,
             uni_is_vacated_space, is_vacated_space, uni_parked_car, parked_car,
      input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
             entry_gate_open, exit_gate_open, entry_denied, exit_denied,
             deny_count, timeout_count
   );

   modport slave (
      input  entry_req, entry_is_uni, entry_pass, exit_req, exit_is_uni, exit_pass,
             uni_is_vacated_space, is_vacated_space, uni_parked_car, parked_car,
      output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
             entry_gate_open, exit_gate_open, entry_denied, exit_denied,
             deny_count, timeout_count
   );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: two independent gate sequencers (entry, exit) that emit one clean
// event pulse per admitted car, plus saturating refusal and timeout statistics.
module parking_gate_fsm #(
   parameter int OPEN_CYCLES  = 8,
   parameter int PULSE_CYCLES = 2,
   parameter int DENY_CYCLES  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic is_uni_i,
   input  logic pass_i,
   input  logic admit_uni_i,
   input  logic admit_std_i,
   output logic gate_open_o,
   output logic event_o,
   output logic is_uni_o,
   output logic denied_o,
   output logic deny_ev_o,
   output logic timeout_ev_o
);
   localparam int MAX_C = (OPEN_CYCLES > PULSE_CYCLES) ?
                          ((OPEN_CYCLES > DENY_CYCLES) ? OPEN_CYCLES : DENY_CYCLES) :
                          ((PULSE_CYCLES > DENY_CYCLES) ? PULSE_CYCLES : DENY_CYCLES);
   localparam int TMR_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_OPEN   = 3'd1,
      ST_COMMIT = 3'd2,
      ST_DENY   = 3'd3,
      ST_CLEAR  = 3'd4
   } state_t;

   state_t            state_q;
   logic [TMR_W-1:0]  timer_q;
   logic              gate_open_q;
   logic              event_q;
   logic              is_uni_q;
   logic              denied_q;
   logic              admit_s;
   logic              open_last_s;

   // Admission decision and statistic strobes, taken from the cycle the gate decides or gives up.
   always_comb begin
      admit_s      = 1'b0;
      deny_ev_o    = 1'b0;
      timeout_ev_o = 1'b0;
      open_last_s  = (timer_q == TMR_W'(OPEN_CYCLES - 1));
      if (is_uni_i) begin
         admit_s = admit_uni_i;
      end else begin
         admit_s = admit_std_i;
      end
      if ((state_q == ST_IDLE) && req_i && !admit_s) begin
         deny_ev_o = 1'b1;
      end else begin
         deny_ev_o = 1'b0;
      end
      if ((state_q == ST_OPEN) && !pass_i && open_last_s) begin
         timeout_ev_o = 1'b1;
      end else begin
         timeout_ev_o = 1'b0;
      end
   end

   // Gate sequencing; the class qualifier is only ever loaded on leaving IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         timer_q     <= {TMR_W{1'b0}};
         gate_open_q <= 1'b0;
         event_q     <= 1'b0;
         is_uni_q    <= 1'b0;
         denied_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               timer_q <= {TMR_W{1'b0}};
               if (req_i) begin
                  is_uni_q <= is_uni_i;
                  if (admit_s) begin
                     state_q     <= ST_OPEN;
                     gate_open_q <= 1'b1;
                  end else begin
                     state_q  <= ST_DENY;
                     denied_q <= 1'b1;
                  end
               end
            end
            ST_OPEN: begin
               if (pass_i) begin
                  state_q     <= ST_COMMIT;
                  gate_open_q <= 1'b0;
                  event_q     <= 1'b1;
                  timer_q     <= {TMR_W{1'b0}};
               end else if (open_last_s) begin
                  state_q     <= ST_CLEAR;
                  gate_open_q <= 1'b0;
                  timer_q     <= {TMR_W{1'b0}};
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            ST_COMMIT: begin
               if (timer_q == TMR_W'(PULSE_CYCLES - 1)) begin
                  state_q <= ST_CLEAR;
                  event_q <= 1'b0;
                  timer_q <= {TMR_W{1'b0}};
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            ST_DENY: begin
               if (timer_q == TMR_W'(DENY_CYCLES - 1)) begin
                  state_q  <= ST_CLEAR;
                  denied_q <= 1'b0;
                  timer_q  <= {TMR_W{1'b0}};
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            ST_CLEAR: begin
               timer_q <= {TMR_W{1'b0}};
               if (!req_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               timer_q     <= {TMR_W{1'b0}};
               gate_open_q <= 1'b0;
               event_q     <= 1'b0;
               denied_q    <= 1'b0;
            end
         endcase
      end
   end

   assign gate_open_o = gate_open_q;
   assign event_o     = event_q;
   assign is_uni_o    = is_uni_q;
   assign denied_o    = denied_q;
endmodule

module parking_gate_ctrl #(
   parameter int OPEN_CYCLES  = 8,
   parameter int PULSE_CYCLES = 2,
   parameter int DENY_CYCLES  = 4,
   parameter int CNT_W        = 16
) (
   input  logic           clk,
   input  logic           rst,
   parking_gate_if.slave  gate_if
);
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
      if (sum[CNT_W]) begin
         return {CNT_W{1'b1}};
      end else begin
         return sum[CNT_W-1:0];
      end
   endfunction

   logic             ent_deny_ev_s, ent_tmo_ev_s, ex_deny_ev_s, ex_tmo_ev_s;
   logic             ex_admit_uni_s, ex_admit_std_s;
   logic [CNT_W-1:0] deny_count_q, deny_count_d;
   logic [CNT_W-1:0] timeout_count_q, timeout_count_d;

   // A car may only leave a class whose signed occupancy is strictly positive.
   assign ex_admit_uni_s = (gate_if.uni_parked_car > 11'sd0);
   assign ex_admit_std_s = (gate_if.parked_car > 11'sd0);

   parking_gate_fsm #(
      .OPEN_CYCLES (OPEN_CYCLES),
      .PULSE_CYCLES(PULSE_CYCLES),
      .DENY_CYCLES (DENY_CYCLES)
   ) u_entry (
      .clk         (clk),
      .rst         (rst),
      .req_i       (gate_if.entry_req),
      .is_uni_i    (gate_if.entry_is_uni),
      .pass_i      (gate_if.entry_pass),
      .admit_uni_i (gate_if.uni_is_vacated_space),
      .admit_std_i (gate_if.is_vacated_space),
      .gate_open_o (gate_if.entry_gate_open),
      .event_o     (gate_if.car_entered),
      .is_uni_o    (gate_if.is_uni_car_entered),
      .denied_o    (gate_if.entry_denied),
      .deny_ev_o   (ent_deny_ev_s),
      .timeout_ev_o(ent_tmo_ev_s)
   );

   parking_gate_fsm #(
      .OPEN_CYCLES (OPEN_CYCLES),
      .PULSE_CYCLES(PULSE_CYCLES),
      .DENY_CYCLES (DENY_CYCLES)
   ) u_exit (
      .clk         (clk),
      .rst         (rst),
      .req_i       (gate_if.exit_req),
      .is_uni_i    (gate_if.exit_is_uni),
      .pass_i      (gate_if.exit_pass),
      .admit_uni_i (ex_admit_uni_s),
      .admit_std_i (ex_admit_std_s),
      .gate_open_o (gate_if.exit_gate_open),
      .event_o     (gate_if.car_exited),
      .is_uni_o    (gate_if.is_uni_car_exited),
      .denied_o    (gate_if.exit_denied),
      .deny_ev_o   (ex_deny_ev_s),
      .timeout_ev_o(ex_tmo_ev_s)
   );

   // Both gates may report in the same cycle, so each counter can step by two.
   always_comb begin
      deny_count_d    = sat_add(deny_count_q, {1'b0, ent_deny_ev_s} + {1'b0, ex_deny_ev_s});
      timeout_count_d = sat_add(timeout_count_q, {1'b0, ent_tmo_ev_s} + {1'b0, ex_tmo_ev_s});
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         deny_count_q    <= {CNT_W{1'b0}};
         timeout_count_q <= {CNT_W{1'b0}};
      end else begin
         deny_count_q    <= deny_count_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign gate_if.deny_count    = deny_count_q;
   assign gate_if.timeout_count = timeout_count_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomized scoreboard bench for parking_gate_ctrl: a transaction-level model predicts each car's
// outcome and timing; a negedge monitor matches DUT events against the per-gate expectation queues.
`timescale 1ns/1ps
module tb_parking_gate_ctrl;
   localparam int OPEN_CYCLES  = 8;
   localparam int PULSE_CYCLES = 2;
   localparam int DENY_CYCLES  = 4;
   localparam int CNT_W        = 16;
   localparam int SMALL_W      = 2;
   localparam int K_PASS = 0, K_DENY = 1, K_TMO = 2;

   typedef struct {
      int kind;
      bit uni;
      int t;
      int t_open;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0, fails = 0;
   longint deny_tot = 0, tmo_tot = 0;
   exp_t expq[2][$];

   logic m_open[2], m_ev[2], m_den[2], m_uni[2];
   int   m_open_t[2], m_ev_t[2], m_den_t[2];
   bit   cur_uni[2];

   parking_gate_if #(.CNT_W(CNT_W))   bus();
   parking_gate_if #(.CNT_W(SMALL_W)) bus2();

   parking_gate_ctrl #(.OPEN_CYCLES(OPEN_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
                       .DENY_CYCLES(DENY_CYCLES), .CNT_W(CNT_W))
      dut (.clk(clk), .rst(rst), .gate_if(bus));
   parking_gate_ctrl #(.OPEN_CYCLES(OPEN_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
                       .DENY_CYCLES(DENY_CYCLES), .CNT_W(SMALL_W))
      dut_small (.clk(clk), .rst(rst), .gate_if(bus2));

   assign bus2.entry_req            = bus.entry_req;
   assign bus2.entry_is_uni         = bus.entry_is_uni;
   assign bus2.entry_pass           = bus.entry_pass;
   assign bus2.exit_req             = bus.exit_req;
   assign bus2.exit_is_uni          = bus.exit_is_uni;
   assign bus2.exit_pass            = bus.exit_pass;
   assign bus2.uni_is_vacated_space = bus.uni_is_vacated_space;
   assign bus2.is_vacated_space     = bus.is_vacated_space;
   assign bus2.uni_parked_car       = bus.uni_parked_car;
   assign bus2.parked_car           = bus.parked_car;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic longint sat(input longint v, input int w);
      longint m;
      m = (longint'(1) << w) - 1;
      return (v > m) ? m : v;
   endfunction

   task automatic check_counts();
      chk("deny_count", bus.deny_count, sat(deny_tot, CNT_W));
      chk("timeout_count", bus.timeout_count, sat(tmo_tot, CNT_W));
      chk("deny_count_small", bus2.deny_count, sat(deny_tot, SMALL_W));
      chk("timeout_count_small", bus2.timeout_count, sat(tmo_tot, SMALL_W));
   endtask

   task automatic check_zero();
      chk("rst_car_entered", bus.car_entered, 0);
      chk("rst_is_uni_entered", bus.is_uni_car_entered, 0);
      chk("rst_car_exited", bus.car_exited, 0);
      chk("rst_is_uni_exited", bus.is_uni_car_exited, 0);
      chk("rst_entry_open", bus.entry_gate_open, 0);
      chk("rst_exit_open", bus.exit_gate_open, 0);
      chk("rst_entry_denied", bus.entry_denied, 0);
      chk("rst_exit_denied", bus.exit_denied, 0);
      chk("rst_deny_count", bus.deny_count, 0);
      chk("rst_timeout_count", bus.timeout_count, 0);
      chk("rst_deny_count_small", bus2.deny_count, 0);
   endtask

   // One car at gate g: issue the request, predict its outcome, then play out pass/req timing.
   task automatic gate_txn(input int g, input bit uni, input int a_uni, input int a_std,
                           input int p, input int h, input int pre);
      int c, last;
      bit admit;
      exp_t e;
      repeat (pre) begin @(posedge clk); #1; end
      c = cyc;
      if (g == 0) begin
         bus.entry_is_uni = uni;
         bus.uni_is_vacated_space = (a_uni != 0);
         bus.is_vacated_space = (a_std != 0);
         bus.entry_pass = (p == 0);
         bus.entry_req = 1'b1;
         admit = uni ? (a_uni != 0) : (a_std != 0);
      end else begin
         bus.exit_is_uni = uni;
         bus.uni_parked_car = 11'(a_uni);
         bus.parked_car = 11'(a_std);
         bus.exit_pass = (p == 0);
         bus.exit_req = 1'b1;
         admit = uni ? (a_uni > 0) : (a_std > 0);
      end
      e.uni = uni;
      e.t_open = c + 1;
      if (!admit) begin
         e.kind = K_DENY; e.t = c + 1; deny_tot++;
      end else if (p >= 1 && p <= OPEN_CYCLES) begin
         e.kind = K_PASS; e.t = c + p + 1;
      end else begin
         e.kind = K_TMO; e.t = c + OPEN_CYCLES + 1; tmo_tot++;
      end
      expq[g].push_back(e);
      last = ((h > OPEN_CYCLES + PULSE_CYCLES + 1) ? h : OPEN_CYCLES + PULSE_CYCLES + 1) + 2;
      while (cyc < c + last) begin
         @(posedge clk); #1;
         if (g == 0) begin
            bus.uni_is_vacated_space = 1'($urandom);
            bus.is_vacated_space = 1'($urandom);
            bus.entry_pass = (cyc == c + p);
            if (cyc >= c + h) bus.entry_req = 1'b0;
         end else begin
            bus.uni_parked_car = 11'($urandom);
            bus.parked_car = 11'($urandom);
            bus.exit_pass = (cyc == c + p);
            if (cyc >= c + h) bus.exit_req = 1'b0;
         end
      end
   endtask

   task automatic mon(input int g, input logic ev, input logic uni, input logic open, input logic den);
      exp_t e;
      if (open && !m_open[g]) m_open_t[g] = cyc;
      if (ev && !m_ev[g]) begin
         m_ev_t[g] = cyc;
         chk("event_has_expectation", expq[g].size() > 0, 1);
         if (expq[g].size() > 0) begin
            e = expq[g].pop_front();
            cur_uni[g] = e.uni;
            chk("event_kind", e.kind, K_PASS);
            chk("event_cycle", cyc, e.t);
            chk("event_class", uni, e.uni);
            chk("class_before_edge", m_uni[g], e.uni);
            chk("open_start", m_open_t[g], e.t_open);
            chk("open_off_at_event", open, 0);
         end
      end
      if (ev) chk("class_stable", uni, cur_uni[g]);
      if (!ev && m_ev[g]) chk("pulse_width", cyc - m_ev_t[g], PULSE_CYCLES);
      if (!open && m_open[g] && !ev) begin
         chk("timeout_has_expectation", expq[g].size() > 0, 1);
         if (expq[g].size() > 0) begin
            e = expq[g].pop_front();
            chk("timeout_kind", e.kind, K_TMO);
            chk("timeout_cycle", cyc, e.t);
            chk("timeout_open_start", m_open_t[g], e.t_open);
         end
      end
      if (den && !m_den[g]) begin
         m_den_t[g] = cyc;
         chk("deny_has_expectation", expq[g].size() > 0, 1);
         if (expq[g].size() > 0) begin
            e = expq[g].pop_front();
            chk("deny_kind", e.kind, K_DENY);
            chk("deny_cycle", cyc, e.t);
            chk("deny_gate_closed", open, 0);
         end
      end
      if (!den && m_den[g]) chk("deny_width", cyc - m_den_t[g], DENY_CYCLES);
      m_open[g] = open;
      m_ev[g] = ev;
      m_den[g] = den;
      m_uni[g] = uni;
   endtask

   // Monitor: samples on the falling edge; a reset discards all tracking and pending expectations.
   always @(negedge clk) begin
      if (rst) begin
         for (int g = 0; g < 2; g++) begin
            m_open[g] = 1'b0; m_ev[g] = 1'b0; m_den[g] = 1'b0; m_uni[g] = 1'b0;
            expq[g].delete();
         end
      end else begin
         mon(0, bus.car_entered, bus.is_uni_car_entered, bus.entry_gate_open, bus.entry_denied);
         mon(1, bus.car_exited, bus.is_uni_car_exited, bus.exit_gate_open, bus.exit_denied);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.entry_req = 1'b0; bus.entry_is_uni = 1'b0; bus.entry_pass = 1'b0;
      bus.exit_req = 1'b0; bus.exit_is_uni = 1'b0; bus.exit_pass = 1'b0;
      bus.uni_is_vacated_space = 1'b0; bus.is_vacated_space = 1'b0;
      bus.uni_parked_car = 11'sd0; bus.parked_car = 11'sd0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_zero();
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed: standard admit with pass, uni refusal, timeout, pass in last open cycle.
      gate_txn(0, 1'b0, 0, 1, 3, 6, 0);
      gate_txn(0, 1'b1, 0, 1, 3, 2, 0);
      check_counts();
      gate_txn(0, 1'b0, 0, 1, 20, 3, 0);
      gate_txn(0, 1'b0, 0, 1, OPEN_CYCLES, 3, 0);
      check_counts();

      // Exit: zero and negative counts refuse, positive count admits.
      gate_txn(1, 1'b0, 3, 0, 2, 2, 0);
      gate_txn(1, 1'b0, 3, -1, 2, 2, 0);
      gate_txn(1, 1'b0, 0, 5, 2, 4, 0);
      check_counts();

      // Overlapping commits with opposite classes.
      fork
         gate_txn(0, 1'b1, 1, 0, 3, 5, 0);
         gate_txn(1, 1'b0, 0, 4, 3, 5, 0);
      join

      // Reset in the middle of an entry pulse.
      bus.entry_is_uni = 1'b1; bus.uni_is_vacated_space = 1'b1; bus.entry_req = 1'b1;
      @(posedge clk); #1;
      bus.entry_pass = 1'b1;
      @(posedge clk); #1;
      bus.entry_pass = 1'b0;
      chk("pulse_before_reset", bus.car_entered, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero();
      deny_tot = 0; tmo_tot = 0;
      rst = 1'b0; bus.entry_req = 1'b0;
      @(posedge clk); #1;

      // Same-cycle double refusals: +2, then +2 from max-1 saturates the narrow counter.
      repeat (2) begin
         fork
            gate_txn(0, 1'b1, 0, 1, 2, 2, 0);
            gate_txn(1, 1'b0, 3, 0, 2, 2, 0);
         join
         check_counts();
      end

      for (int r = 0; r < 150; r++) begin
         fork
            begin
               if ($urandom_range(0, 3) != 0)
                  gate_txn(0, 1'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 10)), int'($urandom_range(1, 14)),
                           int'($urandom_range(0, 2)));
            end
            begin
               if ($urandom_range(0, 3) != 0)
                  gate_txn(1, 1'($urandom), int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3,
                           int'($urandom_range(0, 10)), int'($urandom_range(1, 14)),
                           int'($urandom_range(0, 2)));
            end
         join
         check_counts();
      end

      @(posedge clk); #1;
      chk("entry_queue_drained", expq[0].size(), 0);
      chk("exit_queue_drained", expq[1].size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
